// File: rtl/bus_arbiter_if.sv
// Native request bus between N masters, the arbiter, and one shared slave.
// Handshake: a request is held on *_valid until the matching ready pulse; ready is a one-cycle completion qualifier.
interface bus_arbiter_if #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
);
   logic [N_MASTERS-1:0]          m_valid;
   logic [N_MASTERS*ADDR_W-1:0]   m_addr;
   logic [N_MASTERS*DATA_W-1:0]   m_wdata;
   logic [N_MASTERS*DATA_W/8-1:0] m_wstrb;
   logic [DATA_W-1:0]             m_rdata;
   logic [N_MASTERS-1:0]          m_ready;
   logic                          s_valid;
   logic [ADDR_W-1:0]             s_addr;
   logic [DATA_W-1:0]             s_wdata;
   logic [DATA_W/8-1:0]           s_wstrb;
   logic [DATA_W-1:0]             s_rdata;
   logic                          s_ready;

   // Arbiter side: it is the slave of the masters and drives the shared slave request.
   modport slave (
      input  m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
      output m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb
   );

   modport master (
      output m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
      input  m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb
   );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one native-bus slave among N_MASTERS masters.
// One IDLE cycle arbitrates; the winner's request is forwarded until s_ready or abort.
module bus_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   bus_arbiter_if.slave     bus,
   output logic             o_state
);
   localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]    r_state;
   logic [GW-1:0] r_grant;
   logic [GW-1:0] r_last;

   logic [GW-1:0] w_winner;
   logic          w_found;
   logic          w_busy;
   int            w_dist;
   int            w_best;

   // Winner is the requester with the smallest distance above the last served master.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_dist   = 0;
      w_best   = N_MASTERS;
      for (int j = 0; j < N_MASTERS; j++) begin
         w_dist = (j + N_MASTERS - 1 - int'(r_last)) % N_MASTERS;
         if (bus.m_valid[j] && (w_dist < w_best)) begin
            w_best   = w_dist;
            w_winner = GW'(j);
            w_found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_last  <= GW'(N_MASTERS - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant <= w_winner;
                  r_state <= ST_BUSY;
               end
            end
            default: begin
               if (bus.s_ready) begin
                  r_last  <= r_grant;
                  r_state <= ST_IDLE;
               end else if (!bus.m_valid[r_grant]) begin
                  // Granted master withdrew: abandon without completion, priority untouched.
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign w_busy      = (r_state == ST_BUSY);
   assign o_state     = r_state;
   assign bus.m_rdata = bus.s_rdata;
   assign bus.s_valid = w_busy & bus.m_valid[r_grant];
   assign bus.s_addr  = w_busy ? bus.m_addr[int'(r_grant)*ADDR_W +: ADDR_W] : '0;
   assign bus.s_wdata = w_busy ? bus.m_wdata[int'(r_grant)*DATA_W +: DATA_W] : '0;
   assign bus.s_wstrb = w_busy ? bus.m_wstrb[int'(r_grant)*(DATA_W/8) +: DATA_W/8] : '0;

   always_comb begin
      bus.m_ready = '0;
      if (w_busy && bus.s_ready) bus.m_ready[r_grant] = 1'b1;
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter with three masters: directed scenarios plus randomized traffic checked every cycle.
module tb_bus_arbiter;
   localparam int NM = 3;

   logic clk;
   logic rst_n;
   logic st;
   logic [NM-1:0] mv;
   logic [31:0]   ma [NM];
   logic [31:0]   mw [NM];
   logic [3:0]    ms [NM];
   logic          sr;
   logic [31:0]   srd;
   logic [31:0]   sl_rdata;
   int            sl_lat;
   int            sl_cnt;
   bit            rnd_mode;
   int            n_checks;
   int            n_pass;
   logic [NM-1:0] last_mready;
   int            own;
   int            lst;
   logic [1:0]    exp_q [$];

   bus_arbiter_if #(.N_MASTERS(NM), .ADDR_W(32), .DATA_W(32)) bus ();

   bus_arbiter #(.N_MASTERS(NM), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst_n), .bus(bus), .o_state(st)
   );

   assign bus.m_valid = mv;
   assign bus.s_ready = sr;
   assign bus.s_rdata = srd;
   for (genvar g = 0; g < NM; g++) begin : g_pack
      assign bus.m_addr[g*32 +: 32]  = ma[g];
      assign bus.m_wdata[g*32 +: 32] = mw[g];
      assign bus.m_wstrb[g*4 +: 4]   = ms[g];
   end

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic wait_done(input int who, input string name);
      int c;
      for (c = 0; c < 30; c++) begin
         step();
         settle();
         if (bus.m_ready[who]) break;
      end
      chk(name, 64'(c < 30), 64'd1);
   endtask

   task automatic new_req(input int i);
      mv[i] = 1'b1;
      ma[i] = $urandom;
      mw[i] = $urandom;
      ms[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
   endtask

   // Next owner: the requester closest above the last served master, wrapping around.
   function automatic int pick(input int last_srv, input logic [NM-1:0] v);
      int best;
      int bd;
      int d;
      best = -1;
      bd   = NM;
      for (int j = 0; j < NM; j++) begin
         d = (j - last_srv - 1 + NM) % NM;
         if (v[j] && d < bd) begin
            bd   = d;
            best = j;
         end
      end
      return best;
   endfunction

   // slave responder: ready sl_lat cycles after the request first appears
   initial begin
      sr = 1'b0;
      srd = '0;
      sl_cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (bus.s_valid) begin
            if (sl_cnt == 0 && rnd_mode) sl_lat = $urandom_range(0, 3);
            sr = (sl_cnt >= sl_lat);
            sl_cnt = sr ? 0 : sl_cnt + 1;
         end else begin
            sr = rnd_mode && ($urandom_range(0, 7) == 0);
            sl_cnt = 0;
         end
         srd = rnd_mode ? 32'($urandom) : sl_rdata;
      end
   end

   // scoreboard: behavioural ownership model compared on every falling edge
   initial begin
      own = -1;
      lst = NM - 1;
   end

   always @(negedge clk) begin
      logic          e_sv;
      logic [31:0]   e_a;
      logic [31:0]   e_w;
      logic [3:0]    e_s;
      logic [NM-1:0] e_r;
      if (!rst_n) begin
         chk("rst_s_valid", 64'(bus.s_valid), 64'd0);
         chk("rst_m_ready", 64'(bus.m_ready), 64'd0);
         chk("rst_s_addr", 64'(bus.s_addr), 64'd0);
         chk("rst_state", 64'(st), 64'd0);
         own = -1;
         lst = NM - 1;
         last_mready = '0;
      end else begin
         e_sv = 1'b0; e_a = '0; e_w = '0; e_s = '0; e_r = '0;
         if (own >= 0) begin
            e_sv = mv[own];
            e_a  = ma[own];
            e_w  = mw[own];
            e_s  = ms[own];
            if (sr) e_r = NM'(1 << own);
         end
         chk("mdl_s_valid", 64'(bus.s_valid), 64'(e_sv));
         chk("mdl_s_addr", 64'(bus.s_addr), 64'(e_a));
         chk("mdl_s_wdata", 64'(bus.s_wdata), 64'(e_w));
         chk("mdl_s_wstrb", 64'(bus.s_wstrb), 64'(e_s));
         chk("mdl_m_ready", 64'(bus.m_ready), 64'(e_r));
         chk("mdl_m_rdata", 64'(bus.m_rdata), 64'(srd));
         chk("mdl_state", 64'(st), 64'(own >= 0));
         last_mready = bus.m_ready;
         if (own < 0) own = pick(lst, mv);
         else if (sr) begin
            lst = own;
            own = -1;
         end else if (!mv[own]) own = -1;
      end
   end

   // driver / directed scenarios / random traffic
   initial begin
      n_checks = 0;
      n_pass = 0;
      rnd_mode = 1'b0;
      sl_lat = 0;
      sl_rdata = '0;
      last_mready = '0;
      mv = '0;
      for (int i = 0; i < NM; i++) begin
         ma[i] = '0; mw[i] = '0; ms[i] = '0;
      end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_s_valid", 64'(bus.s_valid), 64'd0);
      chk("reset_m_ready", 64'(bus.m_ready), 64'd0);
      chk("reset_state", 64'(st), 64'd0);
      step();
      step();
      rst_n = 1'b1;

      // single read from master 0, slave ready 3 cycles after s_valid
      step(); mv = 3'b001; ma[0] = 32'h100; sl_lat = 3; sl_rdata = 32'hDEADBEEF; settle();
      chk("t1_arb_cycle", 64'(bus.s_valid), 64'd0);
      step(); settle();
      chk("t1_s_valid", 64'(bus.s_valid), 64'd1);
      chk("t1_s_addr", 64'(bus.s_addr), 64'h100);
      chk("t1_s_wstrb", 64'(bus.s_wstrb), 64'h0);
      for (int i = 0; i < 2; i++) begin
         step(); settle();
         chk("t1_wait", 64'(bus.m_ready), 64'd0);
      end
      step(); settle();
      chk("t1_m_ready", 64'(bus.m_ready), 64'b001);
      chk("t1_m_rdata", 64'(bus.m_rdata), 64'hDEADBEEF);
      step(); mv = '0; settle();
      chk("t1_idle", 64'(st), 64'd0);

      // contention fairness after a fresh reset
      step(); rst_n = 1'b0; settle();
      step(); rst_n = 1'b1; mv = 3'b011; ma[0] = 32'h1000; ma[1] = 32'h1004; sl_lat = 1;
      exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         logic [1:0] e;
         step(); settle();
         if (bus.m_ready != '0) begin
            e = exp_q.pop_front();
            chk("t2_grant", 64'(bus.m_ready), 64'(1) << e);
            chk("t2_addr", 64'(bus.s_addr), 64'(ma[e]));
         end
      end
      chk("t2_all_done", 64'(exp_q.size()), 64'd0);
      step(); mv = '0; settle();

      // write routing from master 1
      step(); mv = 3'b010; ma[1] = 32'h204; mw[1] = 32'h12345678; ms[1] = 4'hF; sl_lat = 2; settle();
      chk("t3_arb_cycle", 64'(bus.s_valid), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step(); settle();
         chk("t3_s_valid", 64'(bus.s_valid), 64'd1);
         chk("t3_s_addr", 64'(bus.s_addr), 64'h204);
         chk("t3_s_wdata", 64'(bus.s_wdata), 64'h12345678);
         chk("t3_s_wstrb", 64'(bus.s_wstrb), 64'hF);
         chk("t3_m_ready", 64'(bus.m_ready), (i == 2) ? 64'b010 : 64'd0);
      end
      step(); mv = '0; ms[1] = '0; settle();

      // grant hold while master 1 requests mid-transaction
      step(); mv = 3'b001; ma[0] = 32'h300; sl_lat = 3; settle();
      step(); settle();
      chk("t4_addr0", 64'(bus.s_addr), 64'h300);
      step(); mv = 3'b011; ma[1] = 32'h400; settle();
      chk("t4_hold1", 64'(bus.s_addr), 64'h300);
      chk("t4_no_ready", 64'(bus.m_ready), 64'd0);
      step(); settle();
      chk("t4_hold2", 64'(bus.s_addr), 64'h300);
      step(); settle();
      chk("t4_m_ready", 64'(bus.m_ready), 64'b001);
      chk("t4_hold3", 64'(bus.s_addr), 64'h300);
      step(); mv = 3'b010; settle();
      chk("t4_gap", 64'(bus.s_valid), 64'd0);
      step(); settle();
      chk("t4_m1_valid", 64'(bus.s_valid), 64'd1);
      chk("t4_m1_addr", 64'(bus.s_addr), 64'h400);
      wait_done(1, "t4_m1_done");
      step(); mv = '0; settle();

      // async reset while master 1 is mid-completion; master 0 served last before it
      step(); mv = 3'b001; ma[0] = 32'h500; sl_lat = 0;
      wait_done(0, "t5_m0_done");
      step(); mv = 3'b010; ma[1] = 32'h504; sl_lat = 1; settle();
      step(); settle();
      chk("t5_busy_m1", 64'(bus.s_addr), 64'h504);
      step(); #2;
      chk("t5_pre_reset", 64'(bus.m_ready), 64'b010);
      rst_n = 1'b0;
      #1;
      chk("t5_async_s_valid", 64'(bus.s_valid), 64'd0);
      chk("t5_async_m_ready", 64'(bus.m_ready), 64'd0);
      chk("t5_async_s_addr", 64'(bus.s_addr), 64'd0);
      chk("t5_async_state", 64'(st), 64'd0);
      step(); rst_n = 1'b1; mv = 3'b011; settle();
      chk("t5_post_idle", 64'(st), 64'd0);
      step(); settle();
      chk("t5_first_grant", 64'(bus.s_addr), 64'h500);
      wait_done(0, "t5_m0_again");
      step(); mv = '0; settle();

      // master 2 served, then master 1 aborts, then all request -> wrap to master 0
      step(); mv = 3'b100; ma[2] = 32'h600; sl_lat = 0;
      wait_done(2, "t6_m2_done");
      step(); mv = 3'b010; ma[1] = 32'h700; sl_lat = 9; settle();
      step(); settle();
      chk("t6_m1_busy", 64'(bus.s_addr), 64'h700);
      step(); mv = '0; settle();
      chk("t6_abort_state", 64'(st), 64'd1);
      chk("t6_abort_s_valid", 64'(bus.s_valid), 64'd0);
      chk("t6_abort_m_ready", 64'(bus.m_ready), 64'd0);
      step(); settle();
      chk("t6_after_abort", 64'(st), 64'd0);
      step(); mv = 3'b111; ma[0] = 32'h800; sl_lat = 0; settle();
      step(); settle();
      chk("t6_wrap_addr", 64'(bus.s_addr), 64'h800);
      chk("t6_wrap_ready", 64'(bus.m_ready), 64'b001);
      step(); mv = '0; settle();

      // randomized traffic: requests, re-requests after completion, occasional aborts
      rnd_mode = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         step();
         for (int i = 0; i < NM; i++) begin
            if (mv[i] && last_mready[i]) begin
               if ($urandom_range(0, 1) == 0) new_req(i);
               else mv[i] = 1'b0;
            end else if (mv[i]) begin
               if ($urandom_range(0, 15) == 0) mv[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               new_req(i);
            end
         end
      end
      step(); mv = '0; rnd_mode = 1'b0;
      repeat (4) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
